// File: rtl/fir_hist_pkg.sv
// fir_hist_pkg: shared types and constants for the FIR coefficient / histogram
// responder. Holds the handshake FSM state enum, default kernel geometry,
// the centre-tap index, the reset-kernel tap function and a rising-edge helper.
package fir_hist_pkg;

  localparam int NUM_COEFFS = 25;
  localparam int COEF_W     = 16;
  localparam int COEF_ONE   = 256;
  localparam int CENTER_TAP = NUM_COEFFS / 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_ACK = 3'd1,
    RD_REQ = 3'd2,
    RD_CAP = 3'd3,
    RD_ACK = 3'd4
  } state_t;

  // Reset kernel: identity filter, unity on the centre tap and zero elsewhere.
  function automatic int reset_tap(input int k, input int n, input int one);
    return (k == n / 2) ? one : 0;
  endfunction

  function automatic logic rising(input logic prev, input logic cur);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// strobe_sync: optional 2-FF synchronizer followed by an optional registered
// rising-edge detect. With SYNC_EN the input is resynchronised into clk; with
// RISE_OUT the output is a one-cycle pulse on a 0->1 transition of the level.
module strobe_sync #(
  parameter bit SYNC_EN  = 1'b1,
  parameter bit RISE_OUT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  import fir_hist_pkg::*;

  logic lvl;

  if (SYNC_EN) begin : g_sync
    logic [1:0] sync_r;
    // Two flops in series to settle a level arriving from another domain.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_r <= 2'b00;
      else        sync_r <= {sync_r[0], d};
    end
    assign lvl = sync_r[1];
  end else begin : g_direct
    assign lvl = d;
  end

  if (RISE_OUT) begin : g_rise
    logic prev;
    // Remember last cycle's level so a 0->1 step can be seen.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= 1'b0;
      else        prev <= lvl;
    end
    assign q = rising(prev, lvl);
  end else begin : g_level
    assign q = lvl;
  end

endmodule

// File: rtl/fir_hist_axi_resp.sv
// fir_hist_axi_resp: pixel-domain target of the CPU strobe/ack register bridge.
// Writes land in a shadow coefficient bank that is copied to the active bank
// on the next vs_i rising edge; reads fetch one histogram bin from RAM.
// Build option: define FIR_HIST_STROBE_SYNC_EN to pass both strobes through
// 2-FF synchronizers so the CPU may sit in another clock domain (+2 cycles).
module fir_hist_axi_resp #(
  parameter int NUM_COEFFS = fir_hist_pkg::NUM_COEFFS,
  parameter int COEF_W     = fir_hist_pkg::COEF_W,
  parameter int COEF_ONE   = fir_hist_pkg::COEF_ONE,
  parameter int ADDR_W     = 8,
  parameter int BIN_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         axi_wr_strobe_i,
  output logic                         axi_wr_ack_o,
  input  logic                         axi_rd_strobe_i,
  output logic                         axi_rd_ack_o,
  input  logic [ADDR_W-1:0]            fir_addr_from_axi,
  input  logic [COEF_W-1:0]            fir_coeff_from_axi,
  output logic [BIN_W-1:0]             hist_bin_to_axi,
  input  logic                         vs_i,
  output logic [NUM_COEFFS*COEF_W-1:0] coef_o,
  output logic                         coef_update_o,
  output logic                         hist_rd_en_o,
  output logic [ADDR_W-1:0]            hist_rd_addr_o,
  input  logic [BIN_W-1:0]             hist_rd_data_i,
  output logic                         addr_err_o
);
  import fir_hist_pkg::*;

  state_t state, state_d;
  logic wr_req, rd_req;
  logic wr_ack_d, rd_ack_d, rd_en_d, accept;
  logic [ADDR_W-1:0] rd_addr_d, addr_q;
  logic [BIN_W-1:0]  bin_d;
  logic signed [COEF_W-1:0] data_q;
  logic signed [COEF_W-1:0] shadow [NUM_COEFFS];
  logic signed [COEF_W-1:0] active [NUM_COEFFS];
  logic pending, vs_rise, commit, wr_do, addr_ok;

`ifdef FIR_HIST_STROBE_SYNC_EN
  strobe_sync #(.SYNC_EN(1'b1), .RISE_OUT(1'b0)) u_wr_sync (
    .clk(clk), .rst_n(rst_n), .d(axi_wr_strobe_i), .q(wr_req));
  strobe_sync #(.SYNC_EN(1'b1), .RISE_OUT(1'b0)) u_rd_sync (
    .clk(clk), .rst_n(rst_n), .d(axi_rd_strobe_i), .q(rd_req));
`else
  assign wr_req = axi_wr_strobe_i;
  assign rd_req = axi_rd_strobe_i;
`endif

  strobe_sync #(.SYNC_EN(1'b0), .RISE_OUT(1'b1)) u_vs_edge (
    .clk(clk), .rst_n(rst_n), .d(vs_i), .q(vs_rise));

  assign commit  = vs_rise & pending;
  assign wr_do   = (state == WR_ACK) && !axi_wr_ack_o;
  assign addr_ok = int'(addr_q) < NUM_COEFFS;

  // Handshake next-state and next-output decode; all outputs are registered.
  always_comb begin
    state_d   = state;
    wr_ack_d  = axi_wr_ack_o;
    rd_ack_d  = axi_rd_ack_o;
    rd_en_d   = 1'b0;
    rd_addr_d = hist_rd_addr_o;
    bin_d     = hist_bin_to_axi;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        // Write has priority; a simultaneous read waits for the write to finish.
        if (wr_req) begin
          state_d = WR_ACK;
          accept  = 1'b1;
        end else if (rd_req) begin
          state_d = RD_REQ;
          accept  = 1'b1;
        end
      end
      WR_ACK: begin
        if (!axi_wr_ack_o) wr_ack_d = 1'b1;
        else if (!wr_req) begin
          wr_ack_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_REQ: begin
        rd_en_d   = 1'b1;
        rd_addr_d = addr_q;
        state_d   = RD_CAP;
      end
      // RAM latency cycle; its data is valid for the first RD_ACK edge.
      RD_CAP: state_d = RD_ACK;
      RD_ACK: begin
        if (!axi_rd_ack_o) begin
          rd_ack_d = 1'b1;
          bin_d    = hist_rd_data_i;
        end else if (!rd_req) begin
          rd_ack_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, handshake outputs and the request address/data captured on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      axi_wr_ack_o    <= 1'b0;
      axi_rd_ack_o    <= 1'b0;
      hist_rd_en_o    <= 1'b0;
      hist_rd_addr_o  <= '0;
      hist_bin_to_axi <= '0;
      addr_q          <= '0;
      data_q          <= '0;
    end else begin
      state           <= state_d;
      axi_wr_ack_o    <= wr_ack_d;
      axi_rd_ack_o    <= rd_ack_d;
      hist_rd_en_o    <= rd_en_d;
      hist_rd_addr_o  <= rd_addr_d;
      hist_bin_to_axi <= bin_d;
      if (accept) begin
        addr_q <= fir_addr_from_axi;
        data_q <= fir_coeff_from_axi;
      end
    end
  end

  // Shadow/active coefficient banks; a same-edge write is left for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_COEFFS; k++) begin
        shadow[k] <= COEF_W'(reset_tap(k, NUM_COEFFS, COEF_ONE));
        active[k] <= COEF_W'(reset_tap(k, NUM_COEFFS, COEF_ONE));
      end
      pending       <= 1'b0;
      coef_update_o <= 1'b0;
      addr_err_o    <= 1'b0;
    end else begin
      coef_update_o <= commit;
      if (commit) begin
        for (int k = 0; k < NUM_COEFFS; k++) active[k] <= shadow[k];
        pending <= 1'b0;
      end
      if (wr_do) begin
        if (addr_ok) begin
          for (int k = 0; k < NUM_COEFFS; k++)
            if (addr_q == ADDR_W'(k)) shadow[k] <= data_q;
          pending <= 1'b1;
        end else begin
          addr_err_o <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_COEFFS; g++) begin : g_coef
    assign coef_o[g*COEF_W +: COEF_W] = active[g];
  end

endmodule
